// File: rtl/riscv_exec_pkg.sv
// Shared encodings for the multicycle RISC-V execute datapath slice.
// Covers the immediate formats, the source-B selects, the ALU operations and the PC word increment.
package riscv_exec_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] WORD_INC = 32'd4;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10,
        SRCB_ZERO = 2'b11
    } src_b_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLL  = 3'b111
    } alu_op_t;

    // Copies the sign bit into the upper bits of a 32-bit word.
    function automatic logic [XLEN-1:0] sign_fill(input logic sign_bit, input int unsigned width);
        logic [XLEN-1:0] mask;
        mask = '0;
        for (int k = 0; k < XLEN; k++) begin
            if (k >= int'(width)) begin
                mask[k] = sign_bit;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/riscv_imm_extend.sv
// Immediate extension unit: rebuilds the I/S/B/J immediate from instruction bits [31:7].
// The immValue bit k holds instruction bit k+7.
module riscv_imm_extend
    import riscv_exec_pkg::*;
(
    input  logic [24:0] immValue,
    input  logic [1:0]  immSrc,
    output logic [31:0] immExt
);

    logic        sign_bit;
    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [20:0] j_field;

    // Instruction bit n lives at immValue[n-7].
    assign sign_bit = immValue[24];
    assign i_field  = immValue[24:13];
    assign s_field  = {immValue[24:18], immValue[4:0]};
    assign b_field  = {immValue[24], immValue[0], immValue[23:18], immValue[4:1], 1'b0};
    assign j_field  = {immValue[24], immValue[12:5], immValue[13], immValue[23:14], 1'b0};

    always_comb begin
        immExt = '0;
        case (imm_src_t'(immSrc))
            IMM_I:   immExt = sign_fill(sign_bit, 12) | {20'd0, i_field};
            IMM_S:   immExt = sign_fill(sign_bit, 12) | {20'd0, s_field};
            IMM_B:   immExt = sign_fill(sign_bit, 13) | {19'd0, b_field};
            IMM_J:   immExt = sign_fill(sign_bit, 21) | {11'd0, j_field};
            default: immExt = '0;
        endcase
    end

endmodule

// File: rtl/riscv_exec_datapath.sv
// Multicycle execute slice: immediate extension, source-B mux, ALU with Zero flag and the ALUOut register.
// Define RISCV_EXEC_EXT_OPS_EN to enable xor/slt/sltu/sll on ALUControl 1xx; otherwise those codes give 0.
module riscv_exec_datapath
    import riscv_exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] RD2,
    input  logic [24:0] immValue,
    input  logic [1:0]  immSrc,
    input  logic [1:0]  ALUSrc,
    input  logic [2:0]  ALUControl,
    output logic [31:0] immExt,
    output logic [31:0] ALUResult,
    output logic        Zero,
    output logic [31:0] ALUOut
);

    logic [31:0] src_b;
    logic [31:0] sum;
    logic        sub_op;

    riscv_imm_extend u_imm_extend (
        .immValue (immValue),
        .immSrc   (immSrc),
        .immExt   (immExt)
    );

    always_comb begin
        src_b = '0;
        case (src_b_t'(ALUSrc))
            SRCB_RD2:  src_b = RD2;
            SRCB_IMM:  src_b = immExt;
            SRCB_FOUR: src_b = WORD_INC;
            SRCB_ZERO: src_b = '0;
            default:   src_b = '0;
        endcase
    end

    // One shared adder: subtraction is A + ~B + 1 with the carry-in coming from the op code.
    assign sub_op = (alu_op_t'(ALUControl) == ALU_SUB);
    assign sum    = srcA + (sub_op ? ~src_b : src_b) + {31'd0, sub_op};

    always_comb begin
        ALUResult = '0;
        case (alu_op_t'(ALUControl))
            ALU_ADD:  ALUResult = sum;
            ALU_SUB:  ALUResult = sum;
            ALU_AND:  ALUResult = srcA & src_b;
            ALU_OR:   ALUResult = srcA | src_b;
`ifdef RISCV_EXEC_EXT_OPS_EN
            ALU_XOR:  ALUResult = srcA ^ src_b;
            ALU_SLT:  ALUResult = {31'd0, ($signed(srcA) < $signed(src_b))};
            ALU_SLTU: ALUResult = {31'd0, (srcA < src_b)};
            ALU_SLL:  ALUResult = srcA << src_b[4:0];
`else
            ALU_XOR:  ALUResult = '0;
            ALU_SLT:  ALUResult = '0;
            ALU_SLTU: ALUResult = '0;
            ALU_SLL:  ALUResult = '0;
`endif
            default:  ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUOut <= '0;
        end else begin
            ALUOut <= ALUResult;
        end
    end

endmodule

// File: tb/tb_riscv_exec_datapath.sv
// Directed self-checking bench for riscv_exec_datapath.
// Expected values are hand-computed; RISCV_EXEC_EXT_OPS_EN selects the extended-op expectations.
module tb_riscv_exec_datapath;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] RD2;
    logic [24:0] immValue;
    logic [1:0]  immSrc;
    logic [1:0]  ALUSrc;
    logic [2:0]  ALUControl;
    logic [31:0] immExt;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ALUOut;

    int testsRun;
    int testsFailed;

    riscv_exec_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .srcA       (srcA),
        .RD2        (RD2),
        .immValue   (immValue),
        .immSrc     (immSrc),
        .ALUSrc     (ALUSrc),
        .ALUControl (ALUControl),
        .immExt     (immExt),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ALUOut     (ALUOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [24:0] imm, input logic [1:0] isrc,
                                 input logic [1:0] bsel, input logic [2:0] op);
        srcA       = a;
        RD2        = b;
        immValue   = imm;
        immSrc     = isrc;
        ALUSrc     = bsel;
        ALUControl = op;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        srcA        = '0;
        RD2         = '0;
        immValue    = '0;
        immSrc      = 2'b00;
        ALUSrc      = 2'b00;
        ALUControl  = 3'b000;
        #2;
        checkOutput("reset_aluout", ALUOut, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'd30, 32'd0, 25'd0, 2'b00, 2'b10, 3'b010);
        checkOutput("const4_and_result", ALUResult, 32'd4);
        checkOutput("const4_and_zero", {31'd0, Zero}, 32'd0);
        @(posedge clk); #1;
        checkOutput("const4_aluout", ALUOut, 32'd4);

        // Asynchronous reset mid-operation: clears without a clock edge.
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_reset_clear", ALUOut, 32'd0);
        checkOutput("reset_comb_follows", ALUResult, 32'd4);
        @(posedge clk); #1;
        checkOutput("reset_hold", ALUOut, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_release_no_edge", ALUOut, 32'd0);
        @(posedge clk); #1;
        checkOutput("first_capture", ALUOut, 32'd4);

        @(negedge clk);
        applyStimulus(32'd30, 32'd0, 25'd15, 2'b01, 2'b01, 3'b000);
        checkOutput("s_imm_ext", immExt, 32'd15);
        checkOutput("s_imm_add", ALUResult, 32'd45);
        @(posedge clk); #1;
        checkOutput("s_imm_aluout", ALUOut, 32'd45);

        @(negedge clk);
        applyStimulus(32'd1, 32'd0, 25'h1FFE000, 2'b00, 2'b01, 3'b000);
        checkOutput("i_imm_neg1", immExt, 32'hFFFFFFFF);
        checkOutput("i_add_wrap", ALUResult, 32'd0);
        checkOutput("i_add_zero", {31'd0, Zero}, 32'd1);

        applyStimulus(32'd0, 32'd0, 25'h0000001, 2'b10, 2'b01, 3'b000);
        checkOutput("b_imm_bit11", immExt, 32'h00000800);
        applyStimulus(32'd0, 32'd0, 25'h1000000, 2'b10, 2'b01, 3'b000);
        checkOutput("b_imm_sign", immExt, 32'hFFFFF000);
        applyStimulus(32'd0, 32'd0, 25'h0000020, 2'b11, 2'b01, 3'b000);
        checkOutput("j_imm_bit12", immExt, 32'h00001000);
        applyStimulus(32'd0, 32'd0, 25'h0002000, 2'b11, 2'b01, 3'b000);
        checkOutput("j_imm_bit11", immExt, 32'h00000800);
        applyStimulus(32'd0, 32'd0, 25'h1000000, 2'b11, 2'b01, 3'b000);
        checkOutput("j_imm_sign", immExt, 32'hFFF00000);
        applyStimulus(32'd0, 32'd0, 25'h0FC001E, 2'b01, 2'b01, 3'b000);
        checkOutput("s_imm_fields", immExt, 32'h000007FE);

        applyStimulus(32'd7, 32'd7, 25'd0, 2'b00, 2'b00, 3'b001);
        checkOutput("sub_equal", ALUResult, 32'd0);
        checkOutput("sub_equal_zero", {31'd0, Zero}, 32'd1);
        applyStimulus(32'd0, 32'd1, 25'd0, 2'b00, 2'b00, 3'b001);
        checkOutput("sub_wrap", ALUResult, 32'hFFFFFFFF);
        checkOutput("sub_wrap_zero", {31'd0, Zero}, 32'd0);

        applyStimulus(32'h000000F0, 32'h0000000F, 25'd0, 2'b00, 2'b00, 3'b011);
        checkOutput("or_rd2", ALUResult, 32'h000000FF);
        applyStimulus(32'h00001234, 32'hDEADBEEF, 25'd0, 2'b00, 2'b11, 3'b000);
        checkOutput("add_srcb_zero", ALUResult, 32'h00001234);

        applyStimulus(32'hFFFFFFFF, 32'd1, 25'd0, 2'b00, 2'b00, 3'b101);
`ifdef RISCV_EXEC_EXT_OPS_EN
        checkOutput("slt_signed", ALUResult, 32'd1);
        checkOutput("slt_zero", {31'd0, Zero}, 32'd0);
`else
        checkOutput("op101_disabled", ALUResult, 32'd0);
        checkOutput("op101_zero", {31'd0, Zero}, 32'd1);
`endif
        applyStimulus(32'hFFFFFFFF, 32'd1, 25'd0, 2'b00, 2'b00, 3'b110);
        checkOutput("sltu_result", ALUResult, 32'd0);
        checkOutput("sltu_zero", {31'd0, Zero}, 32'd1);

        applyStimulus(32'h000000FF, 32'h0000000F, 25'd0, 2'b00, 2'b00, 3'b100);
`ifdef RISCV_EXEC_EXT_OPS_EN
        checkOutput("xor_result", ALUResult, 32'h000000F0);
`else
        checkOutput("op100_disabled", ALUResult, 32'd0);
`endif
        applyStimulus(32'd1, 32'd35, 25'd0, 2'b00, 2'b00, 3'b111);
`ifdef RISCV_EXEC_EXT_OPS_EN
        checkOutput("sll_low5", ALUResult, 32'd8);
`else
        checkOutput("op111_disabled", ALUResult, 32'd0);
`endif
        @(posedge clk); #1;
`ifdef RISCV_EXEC_EXT_OPS_EN
        checkOutput("sll_aluout", ALUOut, 32'd8);
`else
        checkOutput("op111_aluout", ALUOut, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
